// File: rtl/csr_trap_regs.sv
// Machine-mode CSR file with atomic trap entry/return and gated external interrupt.
// Optional mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_trap_regs #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter int unsigned IRQ_HOLDOFF = 4,
   parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_w,
   input  logic [1:0]  csr_wsc_mode,
   input  logic [11:0] csr_raddr,
   input  logic [11:0] csr_waddr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   input  logic        illegal_inst,
   input  logic        ecall_m,
   input  logic        l_access_fault,
   input  logic        s_access_fault,
   input  logic [31:0] fault_val,
   input  logic        ext_irq,
   input  logic        mret,
   input  logic [31:0] epc_cur,
   input  logic [31:0] epc_next,
`ifdef CSR_COUNTERS_EN
   input  logic        instret_pulse,
`endif
   output logic        redirect,
   output logic [31:0] PC_redirect,
   output logic [31:0] mstatus_out
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MISA     = 12'h301;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
`ifdef CSR_COUNTERS_EN
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
`endif

   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic        mie_meie_q, mie_meie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [1:0]  irq_sync_q;
   logic [3:0]  holdoff_q, holdoff_d;
`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;
`endif

   logic        meip;
   logic        exc;
   logic        irq_take;
   logic        wr_en;
   logic [31:0] exc_cause;
   logic        exc_has_tval;
   logic [31:0] mtvec_base;
   logic [31:0] old_val;
   logic [31:0] new_val;

   assign meip        = irq_sync_q[1];
   assign mstatus_out = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
   assign mtvec_base  = {mtvec_q[31:2], 2'b00};

   function automatic logic [31:0] csr_view(input logic [11:0] addr);
      logic [31:0] v;
      v = 32'h0;
      case (addr)
         ADDR_MSTATUS:  v = mstatus_out;
         ADDR_MISA:     v = MISA_VALUE;
         ADDR_MIE:      v = {20'b0, mie_meie_q, 11'b0};
         ADDR_MTVEC:    v = mtvec_q;
         ADDR_MSCRATCH: v = mscratch_q;
         ADDR_MEPC:     v = mepc_q;
         ADDR_MCAUSE:   v = mcause_q;
         ADDR_MTVAL:    v = mtval_q;
         ADDR_MIP:      v = {20'b0, meip, 11'b0};
`ifdef CSR_COUNTERS_EN
         ADDR_MCYCLE:    v = mcycle_q[31:0];
         ADDR_MCYCLEH:   v = mcycle_q[63:32];
         ADDR_MINSTRET:  v = minstret_q[31:0];
         ADDR_MINSTRETH: v = minstret_q[63:32];
`endif
         default:       v = 32'h0;
      endcase
      return v;
   endfunction

   assign csr_rdata = csr_view(csr_raddr);
   assign old_val   = csr_view(csr_waddr);

   always_comb begin
      exc          = illegal_inst | ecall_m | l_access_fault | s_access_fault;
      exc_has_tval = 1'b0;
      if (illegal_inst)        exc_cause = 32'd2;
      else if (ecall_m)        exc_cause = 32'd11;
      else if (l_access_fault) begin
         exc_cause    = 32'd5;
         exc_has_tval = 1'b1;
      end else begin
         exc_cause    = 32'd7;
         exc_has_tval = s_access_fault;
      end
      irq_take = !exc && !mret && (holdoff_q == 4'd0) && mstatus_mie_q && mie_meie_q && meip;
      redirect = exc | mret | irq_take;
      if (exc)                      PC_redirect = mtvec_base;
      else if (mret)                PC_redirect = mepc_q;
      else if (irq_take)            PC_redirect = mtvec_q[0] ? mtvec_base + 32'd44 : mtvec_base;
      else                          PC_redirect = mtvec_q;
   end

   always_comb begin
      case (csr_wsc_mode)
         2'b01:   new_val = csr_wdata;
         2'b10:   new_val = old_val | csr_wdata;
         2'b11:   new_val = old_val & ~csr_wdata;
         default: new_val = old_val;
      endcase
   end

   // Any trap or mret swallows the CSR write of that cycle, whatever its target.
   assign wr_en = csr_w && (csr_wsc_mode != 2'b00) && !redirect;

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_meie_d     = mie_meie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
`ifdef CSR_COUNTERS_EN
      mcycle_d       = mcycle_q + 64'd1;
      minstret_d     = minstret_q + {63'b0, instret_pulse};
`endif

      if (wr_en) begin
         case (csr_waddr)
            ADDR_MSTATUS: begin
               mstatus_mie_d  = new_val[3];
               mstatus_mpie_d = new_val[7];
            end
            ADDR_MIE:      mie_meie_d = new_val[11];
            ADDR_MTVEC:    mtvec_d    = {new_val[31:2], 1'b0, new_val[0]};
            ADDR_MSCRATCH: mscratch_d = new_val;
            ADDR_MEPC:     mepc_d     = {new_val[31:2], 2'b00};
            ADDR_MCAUSE:   mcause_d   = new_val;
            ADDR_MTVAL:    mtval_d    = new_val;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val};
            ADDR_MCYCLEH:   mcycle_d   = {new_val, mcycle_q[31:0]};
            ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
            ADDR_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
`endif
            default: ;
         endcase
      end

      if (exc) begin
         mepc_d         = {epc_cur[31:2], 2'b00};
         mcause_d       = exc_cause;
         mtval_d        = exc_has_tval ? fault_val : 32'h0;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (irq_take) begin
         mepc_d         = {epc_next[31:2], 2'b00};
         mcause_d       = 32'h8000_000B;
         mtval_d        = 32'h0;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end

      if (redirect)                holdoff_d = 4'(IRQ_HOLDOFF);
      else if (holdoff_q != 4'd0)  holdoff_d = holdoff_q - 4'd1;
      else                         holdoff_d = 4'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_meie_q     <= 1'b0;
         mtvec_q        <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
         mscratch_q     <= 32'h0;
         mepc_q         <= 32'h0;
         mcause_q       <= 32'h0;
         mtval_q        <= 32'h0;
         irq_sync_q     <= 2'b00;
         holdoff_q      <= 4'd0;
`ifdef CSR_COUNTERS_EN
         mcycle_q       <= 64'd0;
         minstret_q     <= 64'd0;
`endif
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_meie_q     <= mie_meie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         irq_sync_q     <= {irq_sync_q[0], ext_irq};
         holdoff_q      <= holdoff_d;
`ifdef CSR_COUNTERS_EN
         mcycle_q       <= mcycle_d;
         minstret_q     <= minstret_d;
`endif
      end
   end

endmodule

// File: tb/tb_csr_trap_regs.sv
// Directed self-checking bench for csr_trap_regs (default build, CSR_COUNTERS_EN optional).
module tb_csr_trap_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_w;
   logic [1:0]  csr_wsc_mode;
   logic [11:0] csr_raddr;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        illegal_inst;
   logic        ecall_m;
   logic        l_access_fault;
   logic        s_access_fault;
   logic [31:0] fault_val;
   logic        ext_irq;
   logic        mret;
   logic [31:0] epc_cur;
   logic [31:0] epc_next;
   logic        instret_pulse;
   logic        redirect;
   logic [31:0] PC_redirect;
   logic [31:0] mstatus_out;

   int n_cmp = 0;
   int n_bad = 0;

   always #50 clk = ~clk;

   csr_trap_regs dut (
      .clk            (clk),
      .rst            (rst),
      .csr_w          (csr_w),
      .csr_wsc_mode   (csr_wsc_mode),
      .csr_raddr      (csr_raddr),
      .csr_waddr      (csr_waddr),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .illegal_inst   (illegal_inst),
      .ecall_m        (ecall_m),
      .l_access_fault (l_access_fault),
      .s_access_fault (s_access_fault),
      .fault_val      (fault_val),
      .ext_irq        (ext_irq),
      .mret           (mret),
      .epc_cur        (epc_cur),
      .epc_next       (epc_next),
`ifdef CSR_COUNTERS_EN
      .instret_pulse  (instret_pulse),
`endif
      .redirect       (redirect),
      .PC_redirect    (PC_redirect),
      .mstatus_out    (mstatus_out)
   );

   task automatic idle();
      csr_w = 0; csr_wsc_mode = 2'b00; csr_waddr = 12'h0; csr_wdata = 32'h0;
      illegal_inst = 0; ecall_m = 0; l_access_fault = 0; s_access_fault = 0;
      mret = 0; instret_pulse = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      csr_raddr = a;
      #1;
      d = csr_rdata;
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
      csr_w = 1; csr_waddr = a; csr_wsc_mode = m; csr_wdata = d;
      step();
      idle();
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst = 1; idle(); ext_irq = 0; fault_val = 0; epc_cur = 0; epc_next = 0;
      csr_raddr = 12'h0;
      step(); step();
      rst = 0;
      #1;
      n_cmp++; if (mstatus_out !== 32'h1800) begin n_bad++;
         $display("FAIL reset_mstatus got %h want %h", mstatus_out, 32'h1800); end
      n_cmp++; if (redirect !== 1'b0) begin n_bad++;
         $display("FAIL reset_redirect got %b want 0", redirect); end
      n_cmp++; if (PC_redirect !== 32'h0) begin n_bad++;
         $display("FAIL reset_pc got %h want 0", PC_redirect); end
      rd(12'h301, v);
      n_cmp++; if (v !== 32'h4000_0100) begin n_bad++;
         $display("FAIL misa got %h want 40000100", v); end
      rd(12'h305, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_mtvec got %h want 0", v); end
      rd(12'h304, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_mie got %h want 0", v); end
      rd(12'h7C0, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped got %h want 0", v); end
   endtask

   task automatic test_csr_rw();
      logic [31:0] v;
      wr(12'h305, 2'b01, 32'h0000_0103);
      rd(12'h305, v);
      n_cmp++; if (v !== 32'h101) begin n_bad++; $display("FAIL mtvec_wr got %h want 101", v); end
      wr(12'h300, 2'b10, 32'h8);
      n_cmp++; if (mstatus_out !== 32'h1808) begin n_bad++;
         $display("FAIL mstatus_set got %h want 1808", mstatus_out); end
      // Read in the write cycle must still see the old value.
      csr_w = 1; csr_waddr = 12'h340; csr_wsc_mode = 2'b01; csr_wdata = 32'hFFFF_00FF;
      rd(12'h340, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL no_bypass got %h want 0", v); end
      step(); idle();
      rd(12'h340, v);
      n_cmp++; if (v !== 32'hFFFF_00FF) begin n_bad++;
         $display("FAIL mscratch_wr got %h want ffff00ff", v); end
      wr(12'h340, 2'b11, 32'h0000_000F);
      rd(12'h340, v);
      n_cmp++; if (v !== 32'hFFFF_00F0) begin n_bad++;
         $display("FAIL mscratch_clr got %h want ffff00f0", v); end
      wr(12'h341, 2'b01, 32'h0000_0123);
      rd(12'h341, v);
      n_cmp++; if (v !== 32'h120) begin n_bad++; $display("FAIL mepc_align got %h want 120", v); end
      wr(12'h304, 2'b01, 32'hFFFF_FFFF);
      rd(12'h304, v);
      n_cmp++; if (v !== 32'h800) begin n_bad++; $display("FAIL mie_mask got %h want 800", v); end
      wr(12'h344, 2'b01, 32'hFFFF_FFFF);
      rd(12'h344, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL mip_ro got %h want 0", v); end
   endtask

   task automatic test_exception();
      logic [31:0] v;
      illegal_inst = 1; epc_cur = 32'h40; fault_val = 32'h999;
      #1;
      n_cmp++; if (redirect !== 1'b1) begin n_bad++;
         $display("FAIL exc_redirect got %b want 1", redirect); end
      n_cmp++; if (PC_redirect !== 32'h100) begin n_bad++;
         $display("FAIL exc_pc got %h want 100", PC_redirect); end
      step(); idle();
      rd(12'h341, v);
      n_cmp++; if (v !== 32'h40) begin n_bad++; $display("FAIL exc_mepc got %h want 40", v); end
      rd(12'h342, v);
      n_cmp++; if (v !== 32'd2) begin n_bad++; $display("FAIL exc_mcause got %h want 2", v); end
      rd(12'h343, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL exc_mtval got %h want 0", v); end
      n_cmp++; if (mstatus_out !== 32'h1880) begin n_bad++;
         $display("FAIL exc_mstatus got %h want 1880", mstatus_out); end
   endtask

   task automatic test_mret();
      mret = 1;
      #1;
      n_cmp++; if (redirect !== 1'b1 || PC_redirect !== 32'h40) begin n_bad++;
         $display("FAIL mret_pc got %b/%h want 1/40", redirect, PC_redirect); end
      step(); idle();
      n_cmp++; if (mstatus_out !== 32'h1888) begin n_bad++;
         $display("FAIL mret_mstatus got %h want 1888", mstatus_out); end
   endtask

   task automatic test_interrupt();
      logic [31:0] v;
      // Holdoff was loaded to 4 at the mret edge; this write burns one count.
      wr(12'h304, 2'b01, 32'h800);
      ext_irq = 1; epc_next = 32'h80;
      #1;
      n_cmp++; if (redirect !== 1'b0) begin n_bad++;
         $display("FAIL irq_early0 got %b want 0", redirect); end
      step();
      n_cmp++; if (redirect !== 1'b0) begin n_bad++;
         $display("FAIL irq_early1 got %b want 0", redirect); end
      step();
      rd(12'h344, v);
      n_cmp++; if (v !== 32'h800) begin n_bad++; $display("FAIL mip_sync got %h want 800", v); end
      n_cmp++; if (redirect !== 1'b0) begin n_bad++;
         $display("FAIL irq_holdoff got %b want 0", redirect); end
      step();
      n_cmp++; if (redirect !== 1'b1 || PC_redirect !== 32'h12C) begin n_bad++;
         $display("FAIL irq_take got %b/%h want 1/12c", redirect, PC_redirect); end
      step();
      ext_irq = 0;
      rd(12'h342, v);
      n_cmp++; if (v !== 32'h8000_000B) begin n_bad++;
         $display("FAIL irq_mcause got %h want 8000000b", v); end
      rd(12'h341, v);
      n_cmp++; if (v !== 32'h80) begin n_bad++; $display("FAIL irq_mepc got %h want 80", v); end
      n_cmp++; if (mstatus_out !== 32'h1880) begin n_bad++;
         $display("FAIL irq_mstatus got %h want 1880", mstatus_out); end
      n_cmp++; if (redirect !== 1'b0) begin n_bad++;
         $display("FAIL irq_once got %b want 0", redirect); end
   endtask

   task automatic test_priority();
      logic [31:0] v;
      illegal_inst = 1; l_access_fault = 1; mret = 1; epc_cur = 32'h44; fault_val = 32'h55;
      csr_w = 1; csr_waddr = 12'h340; csr_wsc_mode = 2'b01; csr_wdata = 32'h1234_5678;
      #1;
      n_cmp++; if (redirect !== 1'b1 || PC_redirect !== 32'h100) begin n_bad++;
         $display("FAIL prio_pc got %b/%h want 1/100", redirect, PC_redirect); end
      step(); idle();
      rd(12'h342, v);
      n_cmp++; if (v !== 32'd2) begin n_bad++; $display("FAIL prio_mcause got %h want 2", v); end
      rd(12'h340, v);
      n_cmp++; if (v !== 32'hFFFF_00F0) begin n_bad++;
         $display("FAIL prio_wr_supp got %h want ffff00f0", v); end
      rd(12'h343, v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL prio_mtval got %h want 0", v); end
      n_cmp++; if (mstatus_out !== 32'h1800) begin n_bad++;
         $display("FAIL prio_mstatus got %h want 1800", mstatus_out); end
      ecall_m = 1; l_access_fault = 1; s_access_fault = 1; fault_val = 32'h77;
      step(); idle();
      rd(12'h342, v);
      n_cmp++; if (v !== 32'd11) begin n_bad++; $display("FAIL ecall_cause got %h want b", v); end
      l_access_fault = 1; s_access_fault = 1; fault_val = 32'h88;
      step(); idle();
      rd(12'h342, v);
      n_cmp++; if (v !== 32'd5) begin n_bad++; $display("FAIL lfault_cause got %h want 5", v); end
      rd(12'h343, v);
      n_cmp++; if (v !== 32'h88) begin n_bad++; $display("FAIL lfault_tval got %h want 88", v); end
   endtask

   task automatic test_store_fault_reset();
      logic [31:0] v;
      s_access_fault = 1; fault_val = 32'hDEAD_0004; epc_cur = 32'h48;
      step(); idle();
      rd(12'h342, v);
      n_cmp++; if (v !== 32'd7) begin n_bad++; $display("FAIL sfault_cause got %h want 7", v); end
      rd(12'h343, v);
      n_cmp++; if (v !== 32'hDEAD_0004) begin n_bad++;
         $display("FAIL sfault_tval got %h want dead0004", v); end
      // Reset arrives together with another trap and must win.
      rst = 1; illegal_inst = 1; epc_cur = 32'h99C;
      step();
      rst = 0; idle();
      #1;
      n_cmp++; if (mstatus_out !== 32'h1800) begin n_bad++;
         $display("FAIL rst2_mstatus got %h want 1800", mstatus_out); end
      n_cmp++; if (redirect !== 1'b0 || PC_redirect !== 32'h0) begin n_bad++;
         $display("FAIL rst2_pc got %b/%h want 0/0", redirect, PC_redirect); end
      for (int i = 0; i < 6; i++) begin
         logic [11:0] a;
         case (i)
            0: a = 12'h304;
            1: a = 12'h305;
            2: a = 12'h340;
            3: a = 12'h341;
            4: a = 12'h342;
            default: a = 12'h343;
         endcase
         rd(a, v);
         n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL rst2_csr_%h got %h want 0", a, v); end
      end
   endtask

   initial begin
      test_reset();
      test_csr_rw();
      test_exception();
      test_mret();
      test_interrupt();
      test_priority();
      test_store_fault_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
